// File: rtl/oversample_filter.sv
// ============================================================================
// Module   : oversample_filter
// Purpose  : Per-channel 2^os sample averaging ahead of pid_filter; optional
//            round-half-up when OS_ROUND_EN is defined (floor otherwise).
// Revision : 1.0
// ============================================================================
`default_nettype none

module oversample_filter #(
  parameter int W_CHAN          = 5,
  parameter int N_CHAN          = 8,
  parameter int W_DIN           = 18,
  parameter int MAX_OS          = 4,
  parameter int W_OS            = 3,
  parameter int W_WR_ADDR       = 16,
  parameter int W_WR_CHAN       = 16,
  parameter int W_WR_DATA       = 48,
  parameter logic [W_WR_ADDR-1:0] OS_RATIO_ADDR   = 16'h0010,
  parameter logic [W_WR_ADDR-1:0] OS_CLR_REQ_ADDR = 16'h0011
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        dv_in,
  input  logic [W_CHAN-1:0]           chan_in,
  input  logic signed [W_DIN-1:0]     data_in,
  input  logic                        wr_en,
  input  logic [W_WR_ADDR-1:0]        wr_addr,
  input  logic [W_WR_CHAN-1:0]        wr_chan,
  input  logic [W_WR_DATA-1:0]        wr_data,
  output logic                        dv_out,
  output logic [W_CHAN-1:0]           chan_out,
  output logic signed [W_DIN-1:0]     data_out
);

  localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int W_SUM = W_DIN + MAX_OS;
  localparam int W_CNT = MAX_OS + 1;
`ifdef OS_ROUND_EN
  localparam int W_ACC = W_SUM + 1;
`else
  localparam int W_ACC = W_SUM;
`endif
  localparam logic [W_CHAN:0]    c_nchan_in = (W_CHAN+1)'(N_CHAN);
  localparam logic [W_WR_CHAN:0] c_nchan_wr = (W_WR_CHAN+1)'(N_CHAN);
  localparam logic [W_OS-1:0]    c_max_os   = W_OS'(MAX_OS);

  logic [W_OS-1:0]         os_mem  [N_CHAN];
  logic signed [W_SUM-1:0] sum_mem [N_CHAN];
  logic [W_CNT-1:0]        cnt_mem [N_CHAN];

  logic                    r_s1_dv;
  logic [W_CHAN-1:0]       r_s1_chan;
  logic signed [W_DIN-1:0] r_s1_data;
  logic signed [W_SUM-1:0] r_s1_sum;
  logic [W_CNT-1:0]        r_s1_cnt;
  logic [W_OS-1:0]         r_s1_os;

  logic [W_IDX-1:0]        w_in_idx, w_s1_idx, w_cfg_idx;
  logic                    w_cfg_hit, w_cfg_ratio, w_s1_take, w_s2_kill;
  logic                    w_wb_en, w_full, w_emit, w_fwd;
  logic [W_OS-1:0]         w_os_wr;
  logic signed [W_SUM-1:0] w_sum_n, w_sum_wb;
  logic [W_CNT-1:0]        w_cnt_n, w_cnt_wb;
  logic [W_ACC-1:0]        w_ofs;
  logic signed [W_ACC-1:0] w_acc, w_shift;
  logic                    w_unused_bits;

  assign w_in_idx  = chan_in[W_IDX-1:0];
  assign w_s1_idx  = r_s1_chan[W_IDX-1:0];
  assign w_cfg_idx = wr_chan[W_IDX-1:0];

  // A config write to a channel clears it and kills that channel's samples in both stages
  always_comb begin
    w_cfg_ratio = wr_en && ({1'b0, wr_chan} < c_nchan_wr) && (wr_addr == OS_RATIO_ADDR);
    w_cfg_hit   = w_cfg_ratio ||
                  (wr_en && ({1'b0, wr_chan} < c_nchan_wr) &&
                   (wr_addr == OS_CLR_REQ_ADDR) && wr_data[0]);
    w_os_wr     = (wr_data[W_OS-1:0] > c_max_os) ? c_max_os : wr_data[W_OS-1:0];
    w_s1_take   = dv_in && ({1'b0, chan_in} < c_nchan_in) &&
                  !(w_cfg_hit && (w_cfg_idx == w_in_idx));
    w_s2_kill   = w_cfg_hit && (w_cfg_idx == w_s1_idx);
  end

  always_comb begin
    w_sum_n  = r_s1_sum + W_SUM'(r_s1_data);
    w_cnt_n  = r_s1_cnt + W_CNT'(1);
    w_full   = (w_cnt_n == (W_CNT'(1) << r_s1_os));
    w_wb_en  = r_s1_dv && !w_s2_kill;
    w_emit   = w_wb_en && w_full;
    w_sum_wb = w_full ? '0 : w_sum_n;
    w_cnt_wb = w_full ? '0 : w_cnt_n;
`ifdef OS_ROUND_EN
    w_ofs    = (W_ACC'(1) << r_s1_os) >> 1;
`else
    w_ofs    = '0;
`endif
    w_acc    = W_ACC'(w_sum_n) + $signed(w_ofs);
    w_shift  = w_acc >>> r_s1_os;
    w_fwd    = w_wb_en && (w_s1_idx == w_in_idx);
  end

  assign w_unused_bits = ^{w_shift[W_ACC-1:W_DIN], wr_data[W_WR_DATA-1:W_OS]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        os_mem[i]  <= '0;
        sum_mem[i] <= '0;
        cnt_mem[i] <= '0;
      end
      r_s1_dv   <= 1'b0;
      r_s1_chan <= '0;
      r_s1_data <= '0;
      r_s1_sum  <= '0;
      r_s1_cnt  <= '0;
      r_s1_os   <= '0;
      dv_out    <= 1'b0;
      chan_out  <= '0;
      data_out  <= '0;
    end else begin
      // Stage 1: fetch state, bypassing memory when stage 2 writes the same channel
      r_s1_dv   <= w_s1_take;
      r_s1_chan <= chan_in;
      r_s1_data <= data_in;
      r_s1_sum  <= w_fwd ? w_sum_wb : sum_mem[w_in_idx];
      r_s1_cnt  <= w_fwd ? w_cnt_wb : cnt_mem[w_in_idx];
      r_s1_os   <= os_mem[w_in_idx];

      if (w_wb_en) begin
        sum_mem[w_s1_idx] <= w_sum_wb;
        cnt_mem[w_s1_idx] <= w_cnt_wb;
      end
      if (w_cfg_hit) begin
        sum_mem[w_cfg_idx] <= '0;
        cnt_mem[w_cfg_idx] <= '0;
        if (w_cfg_ratio) os_mem[w_cfg_idx] <= w_os_wr;
      end

      dv_out <= w_emit;
      if (w_emit) begin
        chan_out <= r_s1_chan;
        data_out <= w_shift[W_DIN-1:0];
      end
    end
  end

endmodule

`default_nettype wire
